// File: rtl/accum_pkg.sv
// -----------------------------------------------------------------------------
// accum_pkg
//
// Shared definitions for the burst accumulator:
//   - default data/sum and burst-counter widths
//   - FSM state encoding used by accum_sequencer
//   - a small helper that performs a widened add so the carry is visible
//
// Build option: ACCUM_SATURATE_EN (consumed by accum_datapath) selects
// clamp-to-all-ones accumulation instead of modulo wrap.
// -----------------------------------------------------------------------------
package accum_pkg;

  localparam int unsigned DefWordLength  = 8;
  localparam int unsigned DefCountLength = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Widened add of two operands; the MSB of the result is the carry out.
  function automatic logic [DefWordLength:0] add_carry_default(
    input logic [DefWordLength-1:0] a,
    input logic [DefWordLength-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/accum_datapath.sv
// -----------------------------------------------------------------------------
// accum_datapath
//
// Adder, running accumulator, sticky overflow flag and the output registers
// that present the last completed burst.
//
// Ports:
//   clk       in   clock, all state on rising edge
//   n_rst     in   synchronous active-low reset
//   clear     in   zero the accumulator and sticky overflow flag
//   enable    in   add data_in into the accumulator (one accepted beat)
//   load      in   copy accumulator/sticky flag to sum_out/overflow
//   data_in   in   operand word
//   sum_out   out  last completed burst sum
//   overflow  out  carry-out status of the burst shown on sum_out
//
// Build option: ACCUM_SATURATE_EN -- when defined, a carry out clamps the
// accumulator to all-ones; otherwise the accumulator wraps modulo 2^Word_Length.
// Overflow reporting is the same in both builds.
// -----------------------------------------------------------------------------
module accum_datapath
  import accum_pkg::*;
#(
  parameter int unsigned Word_Length = DefWordLength
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   load,
  input  logic [Word_Length-1:0] data_in,
  output logic [Word_Length-1:0] sum_out,
  output logic                   overflow
);

  logic [Word_Length-1:0] acc_q, acc_d;
  logic                   sticky_q, sticky_d;
  logic [Word_Length-1:0] sum_q, sum_d;
  logic                   ovf_q, ovf_d;

  logic [Word_Length:0]   add_full;
  logic                   carry;

  assign add_full = {1'b0, acc_q} + {1'b0, data_in};
  assign carry    = add_full[Word_Length];

  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (clear) begin
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (enable) begin
`ifdef ACCUM_SATURATE_EN
      // Once clamped, any further non-zero beat carries again, so the
      // accumulator stays at all-ones for the rest of the burst.
      acc_d = carry ? {Word_Length{1'b1}} : add_full[Word_Length-1:0];
`else
      acc_d = add_full[Word_Length-1:0];
`endif
      sticky_d = sticky_q | carry;
    end
  end

  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (load) begin
      sum_d = acc_q;
      ovf_d = sticky_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum_out  = sum_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/accum_sequencer.sv
// -----------------------------------------------------------------------------
// accum_sequencer
//
// Accepts a burst of burst_len operand words over a valid/ready handshake,
// sums them, and presents the result with a one-cycle sum_valid pulse.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   n_rst      in   synchronous active-low reset
//   start      in   request a burst (sampled only in IDLE)
//   burst_len  in   beats in the burst (sampled with start; 0 is ignored)
//   in_valid   in   data_in qualifier
//   data_in    in   operand word
//   in_ready   out  a beat can be accepted (ACCUM only)
//   busy       out  high in every state except IDLE
//   sum_out    out  last completed burst sum, held until next completion
//   sum_valid  out  one-cycle pulse when sum_out updates
//   overflow   out  carry-out status of the burst on sum_out
//
// Build option: ACCUM_SATURATE_EN (see accum_datapath) selects saturating
// accumulation; the default build wraps.
//
// Timing: start at edge k -> in_ready high after edge k+1; last transfer at
// edge m -> sum_valid high after edge m+1, low after edge m+2.
// -----------------------------------------------------------------------------
module accum_sequencer
  import accum_pkg::*;
#(
  parameter int unsigned Word_Length  = DefWordLength,
  parameter int unsigned Count_Length = DefCountLength
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic [Count_Length-1:0] burst_len,
  input  logic                    in_valid,
  input  logic [Word_Length-1:0]  data_in,
  output logic                    in_ready,
  output logic                    busy,
  output logic [Word_Length-1:0]  sum_out,
  output logic                    sum_valid,
  output logic                    overflow
);

  state_e                  state_q;
  logic [Count_Length-1:0] count_q;
  logic [Count_Length-1:0] len_q;
  logic                    in_ready_q;
  logic                    busy_q;
  logic                    sum_valid_q;

  logic                    beat_xfer;
  logic                    dp_clear;
  logic                    dp_load;

  // in_ready_q is only ever high in ACCUM, so this is the whole transfer rule.
  assign beat_xfer = in_valid & in_ready_q;
  assign dp_clear  = (state_q == CLEAR);
  assign dp_load   = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && (burst_len != '0)) begin
            len_q   <= burst_len;
            busy_q  <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          count_q    <= len_q;
          in_ready_q <= 1'b1;
          state_q    <= ACCUM;
        end
        ACCUM: begin
          if (beat_xfer) begin
            count_q <= count_q - Count_Length'(1);
            // Drop ready on the last beat so no extra beat can slip in.
            if (count_q == Count_Length'(1)) begin
              in_ready_q <= 1'b0;
              state_q    <= DONE;
            end
          end
        end
        DONE: begin
          sum_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  accum_datapath #(
    .Word_Length (Word_Length)
  ) u_datapath (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (dp_clear),
    .enable   (beat_xfer),
    .load     (dp_load),
    .data_in  (data_in),
    .sum_out  (sum_out),
    .overflow (overflow)
  );

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign sum_valid = sum_valid_q;

endmodule
